// File: rtl/viz_pkg.sv
// Shared types for the field-visualisation path.
// Mode encoding and the default phase scale.
package viz_pkg;

  typedef enum logic [1:0] {
    MODE_HUE        = 2'd0,
    MODE_HUE_SCALED = 2'd1,
    MODE_GRAY       = 2'd2,
    MODE_HUE_THRESH = 2'd3
  } viz_mode_e;

  localparam int PI_DEFAULT = 25736;

endpackage

// File: rtl/hue_sector_lut.sv
// Hue code to RGB: six linear sectors of 2^COLOR_W steps each.
// Pure combinational, reusable outside the phase pipe.
module hue_sector_lut #(
  parameter int COLOR_W = 8
) (
  input  logic [COLOR_W+2:0] h,
  output logic [COLOR_W-1:0] r,
  output logic [COLOR_W-1:0] g,
  output logic [COLOR_W-1:0] b
);

  localparam logic [COLOR_W-1:0] M = '1;

  logic [2:0]         s;
  logic [COLOR_W-1:0] f;
  logic [COLOR_W-1:0] mf;

  assign s  = h[COLOR_W+2:COLOR_W];
  assign f  = h[COLOR_W-1:0];
  assign mf = M - f;

  always_comb begin
    r = '0;
    g = '0;
    b = '0;
    unique case (s)
      3'd0: begin r = M;  g = f;  end
      3'd1: begin r = mf; g = M;  end
      3'd2: begin g = M;  b = f;  end
      3'd3: begin g = mf; b = M;  end
      3'd4: begin r = f;  b = M;  end
      3'd5: begin r = M;  b = mf; end
      default: ;
    endcase
  end

endmodule

// File: rtl/phase_to_rgb_pipe.sv
// Three-stage phase to RGB mapper with valid/ready backpressure.
// Stages: clamp/offset, exact normalise, colour plus mode.
module phase_to_rgb_pipe
  import viz_pkg::*;
#(
  parameter int PHASE_W = 16,
  parameter int PI_VAL  = PI_DEFAULT,
  parameter int COLOR_W = 8,
  parameter int MAG_W   = 8,
  parameter int THRESH  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PHASE_W-1:0] phase,
  input  logic [MAG_W-1:0]   mag,
  input  logic [1:0]         mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [COLOR_W-1:0] r,
  output logic [COLOR_W-1:0] g,
  output logic [COLOR_W-1:0] b,
  output logic               out_clip
);

  localparam int UW = PHASE_W + 1;
  localparam int HW = COLOR_W + 3;
  localparam int NW = UW + 2 + COLOR_W;

  localparam logic signed [UW-1:0] PI_S  = UW'(PI_VAL);
  localparam logic        [UW-1:0] U_MAX = UW'(2 * PI_VAL - 1);
  localparam logic        [MAG_W-1:0] THR = MAG_W'(THRESH);

  if (MAG_W < COLOR_W) begin : g_bad_mag_w
    $error("MAG_W must be >= COLOR_W");
  end
  if (PI_VAL <= 0 || PI_VAL >= (1 << (PHASE_W - 1))) begin : g_bad_pi
    $error("PI_VAL out of range for PHASE_W");
  end

  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // S1: clamp to [-pi, pi) and shift to an unsigned offset
  logic signed [UW-1:0] ph_x;
  logic signed [UW-1:0] sum;
  logic                 lo;
  logic                 hi;
  logic [UW-1:0]        u_nxt;

  assign ph_x  = {phase[PHASE_W-1], phase};
  assign sum   = ph_x + PI_S;
  assign lo    = ph_x < -PI_S;
  assign hi    = ph_x >= PI_S;
  assign u_nxt = lo ? '0 : (hi ? U_MAX : sum);

  logic             v1;
  logic [UW-1:0]    u1;
  logic             clip1;
  viz_mode_e        mode1;
  logic [MAG_W-1:0] mag1;

  // S2: h = floor(u * 3 * 2^COLOR_W / PI_VAL), exact constant divide
  logic [NW-1:0] num;
  logic [HW-1:0] h_nxt;

  assign num   = (NW'(u1) * NW'(3)) << COLOR_W;
  assign h_nxt = HW'(num / NW'(PI_VAL));

  logic             v2;
  logic [HW-1:0]    h2;
  logic             clip2;
  viz_mode_e        mode2;
  logic [MAG_W-1:0] mag2;

  // S3: sector colour then per-beat mode
  logic [COLOR_W-1:0] lr, lg, lb;
  logic [COLOR_W-1:0] cr, cg, cb;

  hue_sector_lut #(.COLOR_W(COLOR_W)) u_lut (
    .h (h2),
    .r (lr),
    .g (lg),
    .b (lb)
  );

  function automatic logic [COLOR_W-1:0] scale(
    input logic [COLOR_W-1:0] c,
    input logic [MAG_W-1:0]   m
  );
    return COLOR_W'(({{MAG_W{1'b0}}, c} * {{COLOR_W{1'b0}}, m}) >> MAG_W);
  endfunction

  always_comb begin
    cr = lr;
    cg = lg;
    cb = lb;
    unique case (1'b1)
      (mode2 == MODE_HUE): ;
      (mode2 == MODE_HUE_SCALED): begin
        if (!(&mag2)) begin
          cr = scale(lr, mag2);
          cg = scale(lg, mag2);
          cb = scale(lb, mag2);
        end
      end
      (mode2 == MODE_GRAY): begin
        cr = mag2[MAG_W-1 -: COLOR_W];
        cg = mag2[MAG_W-1 -: COLOR_W];
        cb = mag2[MAG_W-1 -: COLOR_W];
      end
      (mode2 == MODE_HUE_THRESH): begin
        if (mag2 < THR) begin
          cr = '0;
          cg = '0;
          cb = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
      r         <= '0;
      g         <= '0;
      b         <= '0;
      out_clip  <= 1'b0;
    end else if (en) begin
      v1        <= in_valid;
      u1        <= u_nxt;
      clip1     <= lo || hi;
      mode1     <= viz_mode_e'(mode);
      mag1      <= mag;
      v2        <= v1;
      h2        <= h_nxt;
      clip2     <= clip1;
      mode2     <= mode1;
      mag2      <= mag1;
      out_valid <= v2;
      r         <= cr;
      g         <= cg;
      b         <= cb;
      out_clip  <= clip2;
    end
  end

endmodule

// File: tb/tb_phase_to_rgb_pipe.sv
// Scoreboard bench for phase_to_rgb_pipe: directed vectors,
// backpressure, mid-stream reset and a strided phase sweep.
module tb_phase_to_rgb_pipe;

  localparam int PI = 25736;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] phase;
  logic [7:0]  mag;
  logic [1:0]  mode;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  r, g, b;
  logic        out_clip;

  phase_to_rgb_pipe #(
    .PHASE_W (16),
    .PI_VAL  (PI),
    .COLOR_W (8),
    .MAG_W   (8),
    .THRESH  (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .phase     (phase),
    .mag       (mag),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .r         (r),
    .g         (g),
    .b         (b),
    .out_clip  (out_clip)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       clip;
    int         t;
  } exp_t;

  typedef struct {
    int ph;
    int mg;
    int md;
    int r;
    int g;
    int b;
    int c;
  } vec_t;

  exp_t q[$];
  exp_t cur_exp;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  bit   chk_lat = 1'b1;
  bit   stall_prev = 1'b0;
  logic [25:0] stall_val;

  vec_t vt[14] = '{
    '{-25736,   0, 0, 255,   0,   0, 0},
    '{     0,   0, 0,   0, 255, 255, 0},
    '{ 25735,   0, 0, 255,   0,   0, 0},
    '{ -8579,   0, 0,   0, 255,   0, 0},
    '{ 32767,   0, 0, 255,   0,   0, 1},
    '{-32768,   0, 0, 255,   0,   0, 1},
    '{ 25736,   0, 0, 255,   0,   0, 1},
    '{-25737,   0, 0, 255,   0,   0, 1},
    '{     0, 128, 1,   0, 127, 127, 0},
    '{     0, 255, 1,   0, 255, 255, 0},
    '{     0, 200, 2, 200, 200, 200, 0},
    '{     0,  15, 3,   0,   0,   0, 0},
    '{     0,  16, 3,   0, 255, 255, 0},
    '{ 32767,   7, 2,   7,   7,   7, 1}
  };

  always @(posedge clk) cyc++;

  function automatic exp_t model(int ph, int mg, int md);
    exp_t   e;
    int     u;
    longint h;
    int     s, f, rr, gg, bb;
    e.clip = 1'b0;
    if (ph < -PI) begin
      u = 0;
      e.clip = 1'b1;
    end else if (ph >= PI) begin
      u = 2 * PI - 1;
      e.clip = 1'b1;
    end else begin
      u = ph + PI;
    end
    h = (longint'(u) * 6 * 256) / (2 * PI);
    s = int'(h / 256);
    f = int'(h % 256);
    rr = 0; gg = 0; bb = 0;
    case (s)
      0: begin rr = 255;     gg = f;       end
      1: begin rr = 255 - f; gg = 255;     end
      2: begin gg = 255;     bb = f;       end
      3: begin gg = 255 - f; bb = 255;     end
      4: begin rr = f;       bb = 255;     end
      default: begin rr = 255; bb = 255 - f; end
    endcase
    if (md == 1 && mg != 255) begin
      rr = (rr * mg) / 256;
      gg = (gg * mg) / 256;
      bb = (bb * mg) / 256;
    end else if (md == 2) begin
      rr = mg; gg = mg; bb = mg;
    end else if (md == 3 && mg < 16) begin
      rr = 0; gg = 0; bb = 0;
    end
    e.r = 8'(rr);
    e.g = 8'(gg);
    e.b = 8'(bb);
    e.t = 0;
    return e;
  endfunction

  function automatic exp_t from_vec(vec_t v);
    exp_t e;
    e.r    = 8'(v.r);
    e.g    = 8'(v.g);
    e.b    = 8'(v.b);
    e.clip = v.c != 0;
    e.t    = 0;
    return e;
  endfunction

  // Call at posedge+#1; returns at posedge+#1 after acceptance.
  task automatic send(input int ph, input int mg, input int md, input exp_t e);
    int n;
    n = 0;
    phase    = 16'(ph);
    mag      = 8'(mg);
    mode     = 2'(md);
    cur_exp  = e;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 200) begin
        $display("FAIL accept_timeout in_ready=%0b required=1", in_ready);
        bad++;
        total++;
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    total++;
    if (q.size() != 0) begin
      $display("FAIL drain pending=%0d required=0", q.size());
      bad++;
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      stall_prev = 1'b0;
    end else begin
      total++;
      if (in_ready !== !(out_valid && !out_ready)) begin
        $display("FAIL in_ready got=%0b required=%0b",
                 in_ready, !(out_valid && !out_ready));
        bad++;
      end
      if (out_valid && !out_ready) begin
        if (stall_prev) begin
          total++;
          if ({r, g, b, out_clip, out_valid} !== stall_val) begin
            $display("FAIL stall_hold got=%h required=%h",
                     {r, g, b, out_clip, out_valid}, stall_val);
            bad++;
          end
        end
        stall_val  = {r, g, b, out_clip, out_valid};
        stall_prev = 1'b1;
      end else begin
        stall_prev = 1'b0;
      end
      if (in_valid && in_ready) begin
        exp_t e;
        e   = cur_exp;
        e.t = cyc;
        q.push_back(e);
      end
      if (out_valid && out_ready) begin
        total++;
        if (q.size() == 0) begin
          $display("FAIL unexpected_pixel got=%h required=none",
                   {r, g, b, out_clip});
          bad++;
        end else begin
          exp_t e;
          e = q.pop_front();
          if ({r, g, b, out_clip} !== {e.r, e.g, e.b, e.clip}) begin
            $display("FAIL pixel got=%h required=%h",
                     {r, g, b, out_clip}, {e.r, e.g, e.b, e.clip});
            bad++;
          end
          if (chk_lat) begin
            total++;
            if (cyc - e.t != 3) begin
              $display("FAIL latency got=%0d required=3", cyc - e.t);
              bad++;
            end
          end
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog cyc=%0d required=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    phase     = '0;
    mag       = '0;
    mode      = '0;
    out_ready = 1'b1;
    cur_exp   = '{8'd0, 8'd0, 8'd0, 1'b0, 0};
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({out_valid, r, g, b, out_clip} !== 26'd0) begin
      $display("FAIL reset_state got=%h required=0",
               {out_valid, r, g, b, out_clip});
      bad++;
    end
    rst = 1'b0;
    @(posedge clk);
    #1;

    foreach (vt[i])
      send(vt[i].ph, vt[i].mg, vt[i].md, from_vec(vt[i]));
    drain();

    chk_lat = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++)
          send(-30000 + i * 7777, 40 + i * 25, i % 4,
               model(-30000 + i * 7777, 40 + i * 25, i % 4));
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    chk_lat = 1'b1;

    send(-20000, 0, 0, model(-20000, 0, 0));
    send(-10000, 0, 0, model(-10000, 0, 0));
    send( 10000, 0, 0, model( 10000, 0, 0));
    rst = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if ({out_valid, r, g, b, out_clip} !== 26'd0) begin
      $display("FAIL mid_reset got=%h required=0",
               {out_valid, r, g, b, out_clip});
      bad++;
    end
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    send(0, 0, 0, model(0, 0, 0));
    drain();

    for (int i = 0; i < 8192; i++) begin
      int ph, mg, md;
      ph = -32768 + i * 8 + (i % 8);
      mg = (i % 17 == 0) ? 255 : int'($urandom_range(0, 255));
      md = i % 4;
      send(ph, mg, md, model(ph, mg, md));
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
